glyph_row_streamer: RTL and testbench
=====================================

Name: glyph_row_streamer

Overview:
- Parametrised successor to the fixed 25x25 glyph bitmap blocks.
- Fetches one glyph's rows from an external row ROM (fixed 1-cycle read latency) and emits a raster pixel stream with valid/ready handshake.
- Supports glyph select, integer scaling 1..4 and abort; sits between the glyph ROMs and the display driver's board compositor.

Parameters:
- GLYPH_W, 25, pixels per glyph row (bits per ROM word)
- GLYPH_H, 25, rows per glyph
- NUM_GLYPHS, 4, number of valid glyph indices
- SEL_W, 2, width of glyph index (2**SEL_W >= NUM_GLYPHS)

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- start  in  1  request a glyph stream; accepted only in IDLE
- glyph_sel  in  SEL_W  glyph index, latched on accepted start
- scale  in  2  scale factor minus 1 (0..3 gives 1x..4x), latched on accepted start
- abort  in  1  terminate stream immediately
- row_rd  out  1  ROM read strobe
- row_glyph  out  SEL_W  ROM glyph index
- row_addr  out  $clog2(GLYPH_H)  ROM row index
- row_data  in  GLYPH_W  ROM word, valid the cycle after row_rd; MSB = leftmost pixel; bit 0 = ink, 1 = background
- pix_valid  out  1  pixel available
- pix_ready  in  1  downstream accepts pixel
- pix_on  out  1  1 = ink
- pix_x  out  $clog2(GLYPH_W*4)  output column
- pix_y  out  $clog2(GLYPH_H*4)  output row
- pix_eol  out  1  last pixel of an output row
- pix_eof  out  1  last pixel of the glyph
- busy  out  1  high in any non-IDLE state
- done  out  1  one-cycle pulse on normal completion

Behaviour:
- Reset (async, any state): FSM to IDLE; row_rd, pix_valid, pix_on, pix_eol, pix_eof, busy, done = 0; pix_x, pix_y, row_addr, row_glyph = 0; latched selection and scale = 0.
- Scale S = scale + 1. Output frame is GLYPH_W*S columns by GLYPH_H*S rows.
- FSM states:
  - IDLE: start=1 latches glyph_sel and scale, then goes to FETCH.
  - FETCH: row_rd=1 for exactly one cycle with the current source row; goes to LOAD.
  - LOAD: captures row_data into the row register; goes to STREAM.
  - STREAM: presents pixels; advances on pix_valid & pix_ready.
  - DONE: done=1 for one cycle; goes to IDLE.
- Latency: start accepted at edge t; row_rd high in cycle t+1; first pix_valid in cycle t+3.
- Source column for output column x is x/S; source row is y/S. Each source row is fetched once and reused for S output rows. A refetch (FETCH, LOAD) happens only when y/S changes, giving 2 bubble cycles per source row.
- Handshake: while pix_valid & !pix_ready, pix_on, pix_x, pix_y, pix_eol and pix_eof hold stable. pix_valid is never withdrawn except by abort or reset.
- pix_eol = 1 when x = GLYPH_W*S-1. pix_eof = pix_eol & (y = GLYPH_H*S-1).
- Transfer with pix_eof goes to DONE. Transfer with pix_eol (not eof) either stays in STREAM with x=0, y+1, or goes to FETCH when the source row changes.
- glyph_sel >= NUM_GLYPHS: no ROM reads (row_rd stays 0). The full frame streams with pix_on=0, same timing minus fetch bubbles.
- start while busy: ignored, no latching.
- abort (any non-IDLE state, priority over start and handshake): next state IDLE, pix_valid=0, no done pulse.
- start and abort in the same IDLE cycle: start is ignored.

Optional Feature:
- GLYPH_MIRROR_EN defined:
  - Adds input port mirror (1 bit), latched with glyph_sel.
  - When the latched value is 1, source column = GLYPH_W-1-(x/S) (horizontal mirror).
  - pix_x still counts 0 upward.
- Undefined: port absent; no mirroring logic.

Test Plan:
- Reset mid-stream: assert reset_n=0 during STREAM at x=7 -> all outputs 0 immediately; busy=0; after release, start works normally.
- S=1, glyph 0, ROM row 1 = 25'b1000000000001111111011111, pix_ready=1 -> output row 1: pix_on=1 at x=1..11 and x=19, else 0; pix_eol at x=24; first pix_valid 3 cycles after start.
- scale=1 (S=2), glyph 2, pix_ready=1 -> 50x50 pixels; row_rd asserted exactly 25 times; pix_eof at x=49,y=49; done one cycle later.
- Backpressure: toggle pix_ready randomly at 50% -> no pixel lost or duplicated; outputs stable while stalled; total 625 transfers at S=1.
- glyph_sel=3 with NUM_GLYPHS=3 -> row_rd never asserted; 625 pixels all pix_on=0; done pulses.
- abort at pix_y=10; start during busy -> abort: IDLE next cycle, no done; start while busy: no effect on latched glyph or stream.

Source files
------------

// File: rtl/glyph_row_streamer_if.sv
// Bus bundle for glyph_row_streamer: control, row-ROM port and pixel stream.
// Optional GLYPH_MIRROR_EN adds the mirror request bit.
interface glyph_row_streamer_if #(
    parameter int unsigned GLYPH_W = 25,
    parameter int unsigned GLYPH_H = 25,
    parameter int unsigned SEL_W   = 2
);
    localparam int unsigned AW = $clog2(GLYPH_H);
    localparam int unsigned XW = $clog2(GLYPH_W * 4);
    localparam int unsigned YW = $clog2(GLYPH_H * 4);

    logic             start;
    logic [SEL_W-1:0] glyph_sel;
    logic [1:0]       scale;
    logic             abort;
`ifdef GLYPH_MIRROR_EN
    logic             mirror;
`endif
    logic             row_rd;
    logic [SEL_W-1:0] row_glyph;
    logic [AW-1:0]    row_addr;
    logic [GLYPH_W-1:0] row_data;
    logic             pix_valid;
    logic             pix_ready;
    logic             pix_on;
    logic [XW-1:0]    pix_x;
    logic [YW-1:0]    pix_y;
    logic             pix_eol;
    logic             pix_eof;
    logic             busy;
    logic             done;

`ifdef GLYPH_MIRROR_EN
    modport master (
        input  start, glyph_sel, scale, abort, mirror, row_data, pix_ready,
        output row_rd, row_glyph, row_addr, pix_valid, pix_on, pix_x, pix_y,
               pix_eol, pix_eof, busy, done
    );
    modport slave (
        output start, glyph_sel, scale, abort, mirror, row_data, pix_ready,
        input  row_rd, row_glyph, row_addr, pix_valid, pix_on, pix_x, pix_y,
               pix_eol, pix_eof, busy, done
    );
`else
    modport master (
        input  start, glyph_sel, scale, abort, row_data, pix_ready,
        output row_rd, row_glyph, row_addr, pix_valid, pix_on, pix_x, pix_y,
               pix_eol, pix_eof, busy, done
    );
    modport slave (
        output start, glyph_sel, scale, abort, row_data, pix_ready,
        input  row_rd, row_glyph, row_addr, pix_valid, pix_on, pix_x, pix_y,
               pix_eol, pix_eof, busy, done
    );
`endif
endinterface

// File: rtl/glyph_row_streamer.sv
// Streams one glyph from a 1-cycle-latency row ROM as a scaled raster pixel stream.
// Optional horizontal mirroring under GLYPH_MIRROR_EN.
module glyph_row_streamer #(
    parameter int unsigned GLYPH_W    = 25,
    parameter int unsigned GLYPH_H    = 25,
    parameter int unsigned NUM_GLYPHS = 4,
    parameter int unsigned SEL_W      = 2
) (
    input  logic clk,
    input  logic reset_n,
    glyph_row_streamer_if.master bus
);
    localparam int unsigned AW = $clog2(GLYPH_H);
    localparam int unsigned CW = $clog2(GLYPH_W);
    localparam int unsigned XW = $clog2(GLYPH_W * 4);
    localparam int unsigned YW = $clog2(GLYPH_H * 4);

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LOAD, S_STREAM, S_DONE} state_t;

    state_t             state_q;
    logic [SEL_W-1:0]   sel_q;
    logic [1:0]         scale_q;
    logic               gvalid_q;
    logic [GLYPH_W-1:0] row_q;
    logic [CW-1:0]      sx_q;
    logic [1:0]         sxr_q;
    logic [AW-1:0]      sy_q;
    logic [1:0]         syr_q;
    logic [XW-1:0]      x_q;
    logic [YW-1:0]      y_q;
    logic               row_rd_q, pix_valid_q, pix_on_q, pix_eol_q, pix_eof_q;
    logic               busy_q, done_q;
`ifdef GLYPH_MIRROR_EN
    logic               mirror_q;
`endif

    logic [CW-1:0] sx_d;
    logic [1:0]    sxr_d;
    logic [AW-1:0] sy_d;
    logic [1:0]    syr_d;
    logic [XW-1:0] x_d;
    logic [YW-1:0] y_d;
    logic          refetch_d, eol_d, eof_d;
    logic          last_sx_rep, last_col, last_row_rep;

    function automatic logic at_eol(input logic [CW-1:0] sx, input logic [1:0] sxr,
                                    input logic [1:0] sc);
        return (sx == CW'(GLYPH_W - 1)) && (sxr == sc);
    endfunction

    function automatic logic at_eof(input logic [CW-1:0] sx, input logic [1:0] sxr,
                                    input logic [AW-1:0] sy, input logic [1:0] syr,
                                    input logic [1:0] sc);
        return at_eol(sx, sxr, sc) && (sy == AW'(GLYPH_H - 1)) && (syr == sc);
    endfunction

    // ROM bit 0 means ink; MSB is the leftmost source column.
    function automatic logic ink(input logic [GLYPH_W-1:0] row, input logic [CW-1:0] sx);
        logic [CW-1:0] idx;
`ifdef GLYPH_MIRROR_EN
        idx = mirror_q ? sx : CW'(GLYPH_W - 1) - sx;
`else
        idx = CW'(GLYPH_W - 1) - sx;
`endif
        return ~row[idx];
    endfunction

    // Position of the pixel following the current transfer; sub-counters replace x/S, y/S.
    always_comb begin
        last_sx_rep  = (sxr_q == scale_q);
        last_col     = last_sx_rep && (sx_q == CW'(GLYPH_W - 1));
        last_row_rep = (syr_q == scale_q);
        sx_d      = sx_q;
        sxr_d     = sxr_q + 2'd1;
        sy_d      = sy_q;
        syr_d     = syr_q;
        x_d       = x_q + XW'(1);
        y_d       = y_q;
        refetch_d = 1'b0;
        if (last_sx_rep) begin
            sxr_d = 2'd0;
            sx_d  = sx_q + CW'(1);
        end
        if (last_col) begin
            sx_d  = '0;
            sxr_d = 2'd0;
            x_d   = '0;
            y_d   = y_q + YW'(1);
            if (last_row_rep) begin
                syr_d     = 2'd0;
                sy_d      = sy_q + AW'(1);
                refetch_d = gvalid_q;
            end else begin
                syr_d = syr_q + 2'd1;
            end
        end
        eol_d = at_eol(sx_d, sxr_d, scale_q);
        eof_d = at_eof(sx_d, sxr_d, sy_d, syr_d, scale_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            sel_q       <= '0;
            scale_q     <= 2'd0;
            gvalid_q    <= 1'b0;
            row_q       <= '0;
            sx_q        <= '0;
            sxr_q       <= 2'd0;
            sy_q        <= '0;
            syr_q       <= 2'd0;
            x_q         <= '0;
            y_q         <= '0;
            row_rd_q    <= 1'b0;
            pix_valid_q <= 1'b0;
            pix_on_q    <= 1'b0;
            pix_eol_q   <= 1'b0;
            pix_eof_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef GLYPH_MIRROR_EN
            mirror_q    <= 1'b0;
`endif
        end else begin
            row_rd_q <= 1'b0;
            done_q   <= 1'b0;
            if (state_q != S_IDLE && bus.abort) begin
                state_q     <= S_IDLE;
                pix_valid_q <= 1'b0;
                pix_on_q    <= 1'b0;
                pix_eol_q   <= 1'b0;
                pix_eof_q   <= 1'b0;
                busy_q      <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (bus.start && !bus.abort) begin
                            sel_q   <= bus.glyph_sel;
                            scale_q <= bus.scale;
`ifdef GLYPH_MIRROR_EN
                            mirror_q <= bus.mirror;
`endif
                            sx_q    <= '0;
                            sxr_q   <= 2'd0;
                            sy_q    <= '0;
                            syr_q   <= 2'd0;
                            x_q     <= '0;
                            y_q     <= '0;
                            busy_q  <= 1'b1;
                            if (32'(bus.glyph_sel) < NUM_GLYPHS) begin
                                gvalid_q <= 1'b1;
                                row_rd_q <= 1'b1;
                                state_q  <= S_FETCH;
                            end else begin
                                // Unknown glyph: blank frame, no ROM traffic.
                                gvalid_q    <= 1'b0;
                                row_q       <= '1;
                                pix_valid_q <= 1'b1;
                                pix_on_q    <= 1'b0;
                                pix_eol_q   <= at_eol('0, 2'd0, bus.scale);
                                pix_eof_q   <= at_eof('0, 2'd0, '0, 2'd0, bus.scale);
                                state_q     <= S_STREAM;
                            end
                        end
                    end
                    S_FETCH: state_q <= S_LOAD;
                    S_LOAD: begin
                        row_q       <= bus.row_data;
                        pix_valid_q <= 1'b1;
                        pix_on_q    <= ink(bus.row_data, sx_q);
                        pix_eol_q   <= at_eol(sx_q, sxr_q, scale_q);
                        pix_eof_q   <= at_eof(sx_q, sxr_q, sy_q, syr_q, scale_q);
                        state_q     <= S_STREAM;
                    end
                    S_STREAM: begin
                        if (pix_valid_q && bus.pix_ready) begin
                            if (pix_eof_q) begin
                                pix_valid_q <= 1'b0;
                                pix_eol_q   <= 1'b0;
                                pix_eof_q   <= 1'b0;
                                done_q      <= 1'b1;
                                state_q     <= S_DONE;
                            end else begin
                                sx_q  <= sx_d;
                                sxr_q <= sxr_d;
                                sy_q  <= sy_d;
                                syr_q <= syr_d;
                                x_q   <= x_d;
                                y_q   <= y_d;
                                if (refetch_d) begin
                                    pix_valid_q <= 1'b0;
                                    pix_eol_q   <= 1'b0;
                                    pix_eof_q   <= 1'b0;
                                    row_rd_q    <= 1'b1;
                                    state_q     <= S_FETCH;
                                end else begin
                                    pix_on_q  <= ink(row_q, sx_d);
                                    pix_eol_q <= eol_d;
                                    pix_eof_q <= eof_d;
                                end
                            end
                        end
                    end
                    S_DONE: begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.row_rd    = row_rd_q;
    assign bus.row_glyph = sel_q;
    assign bus.row_addr  = sy_q;
    assign bus.pix_valid = pix_valid_q;
    assign bus.pix_on    = pix_on_q;
    assign bus.pix_x     = x_q;
    assign bus.pix_y     = y_q;
    assign bus.pix_eol   = pix_eol_q;
    assign bus.pix_eof   = pix_eof_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_glyph_row_streamer.sv
// Scoreboard bench for glyph_row_streamer: expected pixels queued at stimulus, checked by a monitor.
module tb_glyph_row_streamer;
    localparam int unsigned W  = 25;
    localparam int unsigned H  = 25;
    localparam int unsigned NG = 3;
    localparam int unsigned SW = 2;

    typedef struct packed {
        logic       on;
        logic [6:0] x;
        logic [6:0] y;
        logic       eol;
        logic       eof;
    } pix_t;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    glyph_row_streamer_if #(.GLYPH_W(W), .GLYPH_H(H), .SEL_W(SW)) bus ();

    glyph_row_streamer #(.GLYPH_W(W), .GLYPH_H(H), .NUM_GLYPHS(NG), .SEL_W(SW)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
    );

`ifdef GLYPH_MIRROR_EN
    initial bus.mirror = 1'b0;
`endif

    int checks = 0, errors = 0;
    int rd_count = 0, done_count = 0, xfer_count = 0;
    bit rand_mode = 1'b0;
    bit expect_done = 1'b0;
    pix_t sb[$];
    logic [127:0] row1_on = '0;
    int row1_eol_x = -1;
    logic [13:0] last_eof = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [W-1:0] rom_word(input int g, input int r);
        logic [31:0] t;
        if (g == 0 && r == 1) return 25'b1000000000001111111011111;
        t = (32'(g) * 32'h0135_79BD) ^ (32'(r) * 32'h0002_468B) ^ 32'h00A5_5A3C;
        return t[W-1:0];
    endfunction

    // Row ROM with one cycle of read latency.
    always @(posedge clk) begin
        if (bus.row_rd === 1'b1) begin
            bus.row_data <= rom_word(int'(bus.row_glyph), int'(bus.row_addr));
            rd_count     <= rd_count + 1;
        end
    end

    initial begin : ready_drv
        forever begin
            @(posedge clk);
            #1;
            bus.pix_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin : monitor
        pix_t got, e;
        logic stalled;
        logic [17:0] cur, prev;
        stalled = 1'b0;
        prev    = '0;
        forever begin
            @(negedge clk);
            if (reset_n !== 1'b1) begin
                stalled     = 1'b0;
                expect_done = 1'b0;
            end else begin
                if (expect_done) begin
                    chk("done_pulse", 32'(bus.done), 32'd1);
                    expect_done = 1'b0;
                end else if (bus.done === 1'b1) begin
                    chk("spurious_done", 32'(bus.done), 32'd0);
                end
                if (bus.done === 1'b1) done_count++;
                cur = {bus.pix_valid, bus.pix_on, bus.pix_x, bus.pix_y, bus.pix_eol, bus.pix_eof};
                if (stalled) chk("stall_hold", 32'(cur), 32'(prev));
                if (bus.pix_valid === 1'b1 && bus.pix_ready === 1'b1 && bus.abort !== 1'b1) begin
                    got = '{bus.pix_on, bus.pix_x, bus.pix_y, bus.pix_eol, bus.pix_eof};
                    xfer_count++;
                    if (got.y == 7'd1) begin
                        row1_on[got.x] = got.on;
                        if (got.eol) row1_eol_x = int'(got.x);
                    end
                    if (got.eof) begin
                        last_eof    = {got.x, got.y};
                        expect_done = 1'b1;
                    end
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL sb_underflow: got pixel x=%0d y=%0d, required none", got.x, got.y);
                    end else begin
                        e = sb.pop_front();
                        if (got !== e) begin
                            errors++;
                            $display("FAIL pixel: got on=%0d x=%0d y=%0d eol=%0d eof=%0d required on=%0d x=%0d y=%0d eol=%0d eof=%0d",
                                     got.on, got.x, got.y, got.eol, got.eof, e.on, e.x, e.y, e.eol, e.eof);
                        end
                    end
                end
                stalled = bus.pix_valid === 1'b1 && bus.pix_ready !== 1'b1 && bus.abort !== 1'b1;
                prev    = cur;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input int g, input int sc, input bit valid);
        int s;
        logic [W-1:0] word;
        pix_t e;
        s = sc + 1;
        for (int y = 0; y < int'(H) * s; y++) begin
            word = rom_word(g, y / s);
            for (int x = 0; x < int'(W) * s; x++) begin
                e.on  = valid ? ~word[int'(W) - 1 - x / s] : 1'b0;
                e.x   = 7'(x);
                e.y   = 7'(y);
                e.eol = (x == int'(W) * s - 1);
                e.eof = e.eol && (y == int'(H) * s - 1);
                sb.push_back(e);
            end
        end
    endtask

    task automatic start_frame(input int g, input int sc, input bit check_lat);
        bus.glyph_sel = SW'(g);
        bus.scale     = 2'(sc);
        bus.start     = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        chk("busy_after_start", 32'(bus.busy), 32'd1);
        if (check_lat) begin
            chk("lat_rd_t1", 32'(bus.row_rd), 32'd1);
            chk("lat_valid_t1", 32'(bus.pix_valid), 32'd0);
            chk("row_glyph", 32'(bus.row_glyph), 32'(g));
            tick();
            chk("lat_rd_t2", 32'(bus.row_rd), 32'd0);
            chk("lat_valid_t2", 32'(bus.pix_valid), 32'd0);
            tick();
            chk("lat_valid_t3", 32'(bus.pix_valid), 32'd1);
        end
    endtask

    task automatic wait_done(input int budget, input string nm);
        int d0;
        int n;
        d0 = done_count;
        n  = 0;
        while (done_count == d0 && n < budget) begin
            tick();
            n++;
        end
        chk(nm, 32'(done_count > d0), 32'd1);
        tick();
        chk({nm, "_sb_empty"}, 32'(sb.size()), 32'd0);
        chk({nm, "_idle"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin : stim
        int r0, x0, d0;
        bit found, pulsed;
        reset_n       = 1'b0;
        bus.start     = 1'b0;
        bus.glyph_sel = '0;
        bus.scale     = 2'd0;
        bus.abort     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 32'(bus.pix_valid), 32'd0);
        chk("rst_rd", 32'(bus.row_rd), 32'd0);
        chk("rst_busy_done", 32'({bus.busy, bus.done}), 32'd0);
        chk("rst_pix", 32'({bus.pix_on, bus.pix_eol, bus.pix_eof, bus.pix_x, bus.pix_y}), 32'd0);
        chk("rst_rom", 32'({bus.row_glyph, bus.row_addr}), 32'd0);
        reset_n = 1'b1;
        tick();

        // S=1 glyph 0 with hand-checked row 1.
        push_frame(0, 0, 1'b1);
        r0 = rd_count;
        start_frame(0, 0, 1'b1);
        wait_done(2000, "s1_g0");
        chk("s1_reads", 32'(rd_count - r0), 32'd25);
        chk("row1_ink", 32'(row1_on[24:0]), 32'h0008_0FFE);
        chk("row1_eol_x", 32'(row1_eol_x), 32'd24);

        // S=2 glyph 2.
        push_frame(2, 1, 1'b1);
        r0 = rd_count;
        start_frame(2, 1, 1'b0);
        wait_done(6000, "s2_g2");
        chk("s2_reads", 32'(rd_count - r0), 32'd25);
        chk("s2_eof_xy", 32'(last_eof), 32'({7'd49, 7'd49}));

        // Random backpressure.
        rand_mode = 1'b1;
        push_frame(1, 0, 1'b1);
        x0 = xfer_count;
        start_frame(1, 0, 1'b0);
        wait_done(5000, "bp_g1");
        chk("bp_xfers", 32'(xfer_count - x0), 32'd625);
        rand_mode = 1'b0;
        tick();

        // Out-of-range glyph: blank frame, no reads.
        push_frame(3, 0, 1'b0);
        r0 = rd_count;
        x0 = xfer_count;
        start_frame(3, 0, 1'b0);
        wait_done(2000, "blank_g3");
        chk("blank_reads", 32'(rd_count - r0), 32'd0);
        chk("blank_xfers", 32'(xfer_count - x0), 32'd625);

        // Start while busy is ignored; abort at row 10.
        push_frame(1, 0, 1'b1);
        start_frame(1, 0, 1'b0);
        found  = 1'b0;
        pulsed = 1'b0;
        for (int n = 0; n < 2000 && !found; n++) begin
            tick();
            bus.start = 1'b0;
            if (bus.pix_valid === 1'b1 && bus.pix_y == 7'd10) found = 1'b1;
            else if (!pulsed && bus.pix_y == 7'd3) begin
                bus.glyph_sel = 2'd2;
                bus.scale     = 2'd3;
                bus.start     = 1'b1;
                pulsed        = 1'b1;
            end
        end
        chk("abort_reached", 32'(found), 32'd1);
        chk("busy_pre_abort", 32'(bus.busy), 32'd1);
        d0 = done_count;
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("abort_valid", 32'(bus.pix_valid), 32'd0);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        sb.delete();
        repeat (5) tick();
        chk("abort_no_done", 32'(done_count - d0), 32'd0);

        // Start together with abort in IDLE is ignored.
        bus.start = 1'b1;
        bus.abort = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        chk("start_abort_busy", 32'(bus.busy), 32'd0);
        chk("start_abort_rd", 32'(bus.row_rd), 32'd0);

        // Reset mid-stream at x=7.
        push_frame(0, 0, 1'b1);
        start_frame(0, 0, 1'b0);
        found = 1'b0;
        for (int n = 0; n < 200 && !found; n++) begin
            if (bus.pix_valid === 1'b1 && bus.pix_x == 7'd7) found = 1'b1;
            else tick();
        end
        chk("x7_reached", 32'(found), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("mrst_valid_busy", 32'({bus.pix_valid, bus.busy, bus.done, bus.row_rd}), 32'd0);
        chk("mrst_pix", 32'({bus.pix_on, bus.pix_eol, bus.pix_eof, bus.pix_x, bus.pix_y}), 32'd0);
        chk("mrst_rom", 32'({bus.row_glyph, bus.row_addr}), 32'd0);
        sb.delete();
        repeat (2) tick();
        reset_n = 1'b1;
        tick();

        push_frame(1, 1, 1'b1);
        r0 = rd_count;
        start_frame(1, 1, 1'b1);
        wait_done(6000, "post_rst_s2");
        chk("post_rst_reads", 32'(rd_count - r0), 32'd25);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end
endmodule
